// File: rtl/mac_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mac_pkg                                                                |
// | Shared defaults and FSM state encoding for the MAC datapath blocks.   |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
package mac_pkg;

  localparam int WIDTH_DEF = 4;
  localparam int NO_DEF    = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/divider_restoring_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | divider_restoring_if                                                   |
// | Load/done handshake and operand/result bus of the restoring divider.  |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
interface divider_restoring_if #(
  parameter int WIDTH = mac_pkg::WIDTH_DEF
);

  logic             load;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             busy;
  logic             done;
  logic             div_by_zero;

  modport master (
    output load, dividend, divisor,
    input  quotient, remainder, busy, done, div_by_zero
  );

  modport slave (
    input  load, dividend, divisor,
    output quotient, remainder, busy, done, div_by_zero
  );

endinterface
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | div_step                                                               |
// | One combinational shift-subtract-select iteration of the divider.     |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
module div_step #(
  parameter int WIDTH = mac_pkg::WIDTH_DEF
) (
  input  wire logic [WIDTH-1:0] r_in,
  input  wire logic [WIDTH-1:0] q_in,
  input  wire logic [WIDTH-1:0] divisor,
  output logic      [WIDTH-1:0] r_next,
  output logic      [WIDTH-1:0] q_next
);

  // The partial remainder is always below the divisor, so its top bit of the
  // (WIDTH+1)-bit form is provably zero and is not carried between steps.
  logic [WIDTH:0] t_w;
  logic           neg_w;

  always_comb begin
    t_w    = {r_in, q_in[WIDTH-1]} - {1'b0, divisor};
    neg_w  = t_w[WIDTH];
    r_next = neg_w ? {r_in[WIDTH-2:0], q_in[WIDTH-1]} : t_w[WIDTH-1:0];
    q_next = {q_in[WIDTH-2:0], ~neg_w};
  end

endmodule
`default_nettype wire

// File: rtl/divider_restoring.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | divider_restoring                                                      |
// | Sequential unsigned restoring divider, one quotient bit per clock.    |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
module divider_restoring
  import mac_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NO    = NO_DEF
) (
  input wire logic          clock,
  input wire logic          clear_n,
  divider_restoring_if.slave bus
);

  localparam logic [NO-1:0] LAST = NO'(WIDTH - 1);

  state_e            state_q,     state_d;
  logic [NO-1:0]     count_q,     count_d;
  logic [WIDTH-1:0]  r_q,         r_d;
  logic [WIDTH-1:0]  qs_q,        qs_d;
  logic [WIDTH-1:0]  dvs_q,       dvs_d;
  logic              zero_q,      zero_d;
  logic [WIDTH-1:0]  quotient_q,  quotient_d;
  logic [WIDTH-1:0]  remainder_q, remainder_d;
  logic              busy_q,      busy_d;
  logic              done_q,      done_d;
  logic              dbz_q,       dbz_d;

  logic [WIDTH-1:0]  step_r_w;
  logic [WIDTH-1:0]  step_q_w;

  div_step #(.WIDTH(WIDTH)) u_step (
    .r_in    (r_q),
    .q_in    (qs_q),
    .divisor (dvs_q),
    .r_next  (step_r_w),
    .q_next  (step_q_w)
  );

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    r_d         = r_q;
    qs_d        = qs_q;
    dvs_d       = dvs_q;
    zero_d      = zero_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    busy_d      = busy_q;
    done_d      = done_q;
    dbz_d       = dbz_q;

    // load restarts from any state, aborting a division in flight.
    if (bus.load) begin
      state_d = ST_RUN;
      count_d = '0;
      r_d     = '0;
      qs_d    = bus.dividend;
      dvs_d   = bus.divisor;
      zero_d  = (bus.divisor == '0);
      busy_d  = 1'b1;
      done_d  = 1'b0;
      dbz_d   = 1'b0;
    end else if (state_q == ST_RUN) begin
      if (zero_q) begin
        // Divide-by-zero takes a single RUN cycle; qs_q still holds the dividend.
        state_d     = ST_DONE;
        quotient_d  = '1;
        remainder_d = qs_q;
        dbz_d       = 1'b1;
        done_d      = 1'b1;
        busy_d      = 1'b0;
      end else begin
        r_d     = step_r_w;
        qs_d    = step_q_w;
        count_d = count_q + NO'(1);
        if (count_q == LAST) begin
          state_d     = ST_DONE;
          quotient_d  = step_q_w;
          remainder_d = step_r_w;
          done_d      = 1'b1;
          busy_d      = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      r_q         <= '0;
      qs_q        <= '0;
      dvs_q       <= '0;
      zero_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      r_q         <= r_d;
      qs_q        <= qs_d;
      dvs_q       <= dvs_d;
      zero_q      <= zero_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      dbz_q       <= dbz_d;
    end
  end

  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;

endmodule
`default_nettype wire
